// File: rtl/osc_pkg.sv
// Shared FSM state encoding and command codes for the command dispatcher.
package osc_pkg;

  typedef enum logic [1:0] {
    ST_IDLE    = 2'd0,
    ST_ARM     = 2'd1,
    ST_RUN     = 2'd2,
    ST_RELEASE = 2'd3
  } state_t;

  localparam logic [7:0] CMD_ABORT       = 8'h00;
  localparam logic [7:0] CMD_TEST        = 8'h11;
  localparam logic [7:0] CMD_SAMPLER     = 8'h21;
  localparam logic [7:0] CMD_SAMPLE_READ = 8'h22;

endpackage

// File: rtl/cmd_dispatcher_watchdog_timer.sv
// Per-run cycle counter: cleared while arming, counts while enabled and
// flags expiry once it has reached CYC-1; it holds there until cleared.
module watchdog_timer #(
  parameter int unsigned     W   = 24,
  parameter logic [W-1:0]    CYC = {W{1'b1}}
) (
  input  logic clk,
  input  logic rst_n,
  input  logic clear,
  input  logic enable,
  output logic expired
);

  localparam logic [W-1:0] LAST = CYC - W'(1);

  logic [W-1:0] count_q;
  logic [W-1:0] count_d;

  assign expired = (count_q == LAST);

  always_comb begin
    count_d = count_q;
    if (clear) begin
      count_d = '0;
    end else if (enable && !expired) begin
      count_d = count_q + W'(1);
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      count_q <= '0;
    end else begin
      count_q <= count_d;
    end
  end

endmodule

// File: rtl/cmd_dispatcher.sv
// Command dispatcher: maps UART command bytes onto one-hot channel activates.
// Optional run timeout is built only when CMD_DISPATCHER_TIMEOUT_EN is defined.
module cmd_dispatcher #(
  parameter int unsigned         NUM_CH      = 4,
  parameter logic [7:0]          CMD_BASE    = osc_pkg::CMD_SAMPLER,
  parameter logic [7:0]          CMD_ABORT   = osc_pkg::CMD_ABORT,
  parameter int unsigned         TIMEOUT_W   = 24,
  parameter logic [TIMEOUT_W-1:0] TIMEOUT_CYC = {TIMEOUT_W{1'b1}}
) (
  input  logic              clk_50mhz,
  input  logic              reset,
  input  logic              cmd_valid,
  input  logic [7:0]        cmd_data,
  input  logic [NUM_CH-1:0] ch_done,
  output logic [NUM_CH-1:0] ch_activate,
  output logic [7:0]        state_code,
  output logic              busy,
  output logic              err_unknown,
  output logic              err_timeout,
  output logic              cmd_dropped
);

  import osc_pkg::*;

  state_t              state_q;
  logic [NUM_CH-1:0]   sel_oh_q;
  logic [NUM_CH-1:0]   ch_activate_q;
  logic [7:0]          state_code_q;
  logic                busy_q;
  logic                err_unknown_q;
  logic                cmd_dropped_q;

  logic [NUM_CH-1:0]   dec_oh;
  logic                cmd_hit;
  logic                done_sel;

  // One comparator per channel; the one-hot result is latched as the selection.
  for (genvar gi = 0; gi < NUM_CH; gi++) begin : g_dec
    assign dec_oh[gi] = (cmd_data == CMD_BASE + 8'(gi));
  end

  assign cmd_hit  = |dec_oh;
  assign done_sel = |(ch_done & sel_oh_q);

`ifdef CMD_DISPATCHER_TIMEOUT_EN
  logic timeout_hit;
  logic err_timeout_q;

  watchdog_timer #(
    .W   (TIMEOUT_W),
    .CYC (TIMEOUT_CYC)
  ) u_watchdog (
    .clk     (clk_50mhz),
    .rst_n   (reset),
    .clear   (state_q == ST_ARM),
    .enable  (state_q == ST_RUN),
    .expired (timeout_hit)
  );

  assign err_timeout = err_timeout_q;
`else
  assign err_timeout = 1'b0;
`endif

  always_ff @(posedge clk_50mhz or negedge reset) begin
    if (!reset) begin
      state_q       <= ST_IDLE;
      sel_oh_q      <= '0;
      ch_activate_q <= '0;
      state_code_q  <= CMD_ABORT;
      busy_q        <= 1'b0;
      err_unknown_q <= 1'b0;
      cmd_dropped_q <= 1'b0;
`ifdef CMD_DISPATCHER_TIMEOUT_EN
      err_timeout_q <= 1'b0;
`endif
    end else begin
      cmd_dropped_q <= 1'b0;
      case (state_q)
        ST_IDLE: begin
          if (cmd_valid) begin
            if (cmd_hit) begin
              sel_oh_q      <= dec_oh;
              state_code_q  <= cmd_data;
              busy_q        <= 1'b1;
              err_unknown_q <= 1'b0;
`ifdef CMD_DISPATCHER_TIMEOUT_EN
              err_timeout_q <= 1'b0;
`endif
              state_q       <= ST_ARM;
            end else if (cmd_data != CMD_ABORT) begin
              err_unknown_q <= 1'b1;
            end
          end
        end
        ST_ARM: begin
          ch_activate_q <= sel_oh_q;
          cmd_dropped_q <= cmd_valid;
          state_q       <= ST_RUN;
        end
        ST_RUN: begin
          // Done wins over timeout and abort; all three leave through RELEASE.
          if (done_sel) begin
            ch_activate_q <= '0;
            state_q       <= ST_RELEASE;
          end
`ifdef CMD_DISPATCHER_TIMEOUT_EN
          else if (timeout_hit) begin
            ch_activate_q <= '0;
            err_timeout_q <= 1'b1;
            state_q       <= ST_RELEASE;
          end
`endif
          else if (cmd_valid) begin
            if (cmd_data == CMD_ABORT) begin
              ch_activate_q <= '0;
              state_q       <= ST_RELEASE;
            end else begin
              cmd_dropped_q <= 1'b1;
            end
          end
        end
        ST_RELEASE: begin
          cmd_dropped_q <= cmd_valid;
          if (!done_sel) begin
            busy_q       <= 1'b0;
            state_code_q <= CMD_ABORT;
            state_q      <= ST_IDLE;
          end
        end
        default: begin
          ch_activate_q <= '0;
          busy_q        <= 1'b0;
          state_code_q  <= CMD_ABORT;
          state_q       <= ST_IDLE;
        end
      endcase
    end
  end

  assign ch_activate = ch_activate_q;
  assign state_code  = state_code_q;
  assign busy        = busy_q;
  assign err_unknown = err_unknown_q;
  assign cmd_dropped = cmd_dropped_q;

endmodule

// File: tb/tb_cmd_dispatcher.sv
// Bench for cmd_dispatcher: vector table, directed corner sequences and a
// randomized run against a behavioural model (honours CMD_DISPATCHER_TIMEOUT_EN).
module tb_cmd_dispatcher;

  localparam int         NCH   = 4;
  localparam logic [7:0] BASE  = 8'h21;
  localparam logic [7:0] ABORT = 8'h00;
  localparam int         TC    = 16;
`ifdef CMD_DISPATCHER_TIMEOUT_EN
  localparam bit TO_EN = 1'b1;
`else
  localparam bit TO_EN = 1'b0;
`endif

  logic           clk = 1'b0;
  logic           rst_n = 1'b0;
  logic           cmd_valid = 1'b0;
  logic [7:0]     cmd_data = 8'h00;
  logic [NCH-1:0] ch_done = '0;
  logic [NCH-1:0] ch_activate;
  logic [7:0]     state_code;
  logic           busy, err_unknown, err_timeout, cmd_dropped;

  int total = 0;
  int bad   = 0;

  cmd_dispatcher #(
    .NUM_CH      (NCH),
    .CMD_BASE    (BASE),
    .CMD_ABORT   (ABORT),
    .TIMEOUT_W   (24),
    .TIMEOUT_CYC (24'd16)
  ) dut (
    .clk_50mhz   (clk),
    .reset       (rst_n),
    .cmd_valid   (cmd_valid),
    .cmd_data    (cmd_data),
    .ch_done     (ch_done),
    .ch_activate (ch_activate),
    .state_code  (state_code),
    .busy        (busy),
    .err_unknown (err_unknown),
    .err_timeout (err_timeout),
    .cmd_dropped (cmd_dropped)
  );

  always #5 clk = ~clk;

  initial begin
    #500000;
    $display("FAIL global_timeout: simulation did not finish in time");
    $fatal(1, "time limit");
  end

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  task automatic chk_out(input string tag, input logic [3:0] a, input logic b,
                         input logic [7:0] c, input logic u, input logic t, input logic d);
    chk({tag, ".activate"},    32'(ch_activate), 32'(a));
    chk({tag, ".busy"},        32'(busy),        32'(b));
    chk({tag, ".state_code"},  32'(state_code),  32'(c));
    chk({tag, ".err_unknown"}, 32'(err_unknown), 32'(u));
    chk({tag, ".err_timeout"}, 32'(err_timeout), 32'(t));
    chk({tag, ".cmd_dropped"}, 32'(cmd_dropped), 32'(d));
  endtask

  // Behavioural model: selected channel (-1 = idle), one-cycle arming,
  // releasing flag and count of RUN cycles spent so far.
  int         m_sel;
  bit         m_arm, m_rel, m_unk, m_to, m_drop;
  int         m_run;
  logic [7:0] m_code;

  task automatic model_reset();
    m_sel = -1; m_arm = 0; m_rel = 0; m_unk = 0; m_to = 0; m_drop = 0;
    m_run = 0; m_code = ABORT;
  endtask

  task automatic model_edge(input logic v, input logic [7:0] d, input logic [3:0] dn);
    int idx;
    idx = int'(d) - int'(BASE);
    m_drop = 0;
    if (m_sel < 0) begin
      if (v) begin
        if (idx >= 0 && idx < NCH) begin
          m_sel = idx; m_code = d; m_unk = 0; m_to = 0; m_arm = 1; m_rel = 0;
        end else if (d != ABORT) begin
          m_unk = 1;
        end
      end
    end else if (m_arm) begin
      m_arm = 0; m_run = 0; m_drop = v;
    end else if (!m_rel) begin
      if (dn[m_sel]) m_rel = 1;
      else if (TO_EN && m_run == TC - 1) begin m_to = 1; m_rel = 1; end
      else if (v) begin
        if (d == ABORT) m_rel = 1;
        else m_drop = 1;
      end
      m_run++;
    end else begin
      m_drop = v;
      if (!dn[m_sel]) begin m_sel = -1; m_rel = 0; end
    end
  endtask

  task automatic chk_model(input string tag);
    logic [3:0] a;
    a = (m_sel >= 0 && !m_arm && !m_rel) ? 4'(1 << m_sel) : 4'd0;
    chk_out(tag, a, m_sel >= 0, (m_sel >= 0) ? m_code : ABORT, m_unk, m_to, m_drop);
  endtask

  task automatic step(input logic v, input logic [7:0] d, input logic [3:0] dn);
    cmd_valid = v; cmd_data = d; ch_done = dn;
    @(posedge clk);
    model_edge(v, d, dn);
    #1;
  endtask

  typedef struct packed {
    logic       v;
    logic [7:0] d;
    logic [3:0] dn;
    logic [3:0] act;
    logic       busy;
    logic [7:0] code;
    logic       unk;
    logic       drop;
  } vec_t;

  function automatic vec_t mk(input logic v, input logic [7:0] d, input logic [3:0] dn,
                              input logic [3:0] act, input logic b, input logic [7:0] code,
                              input logic unk, input logic drop);
    vec_t r;
    r.v = v; r.d = d; r.dn = dn; r.act = act; r.busy = b; r.code = code; r.unk = unk; r.drop = drop;
    return r;
  endfunction

  vec_t tbl[25];

  initial begin
    int n_act;
    logic [NCH-1:0] done_r;
    logic [7:0] rd;
    logic rv;

    #1;
    chk_out("reset_async", 4'h0, 1'b0, ABORT, 1'b0, 1'b0, 1'b0);
    repeat (2) @(posedge clk);
    @(negedge clk);
    rst_n = 1'b1;
    model_reset();

    // valid, data, done -> activate, busy, state_code, err_unknown, cmd_dropped
    tbl[0]  = mk(1, 8'h55, 4'h0, 4'h0, 0, 8'h00, 1, 0);
    tbl[1]  = mk(0, 8'h00, 4'h0, 4'h0, 0, 8'h00, 1, 0);
    tbl[2]  = mk(1, 8'h21, 4'h0, 4'h0, 1, 8'h21, 0, 0);
    tbl[3]  = mk(0, 8'h00, 4'h0, 4'h1, 1, 8'h21, 0, 0);
    tbl[4]  = mk(0, 8'h00, 4'h1, 4'h0, 1, 8'h21, 0, 0);
    tbl[5]  = mk(0, 8'h00, 4'h1, 4'h0, 1, 8'h21, 0, 0);
    tbl[6]  = mk(0, 8'h00, 4'h0, 4'h0, 0, 8'h00, 0, 0);
    tbl[7]  = mk(1, 8'h23, 4'h0, 4'h0, 1, 8'h23, 0, 0);
    tbl[8]  = mk(0, 8'h00, 4'h0, 4'h4, 1, 8'h23, 0, 0);
    tbl[9]  = mk(1, 8'h21, 4'h0, 4'h4, 1, 8'h23, 0, 1);
    tbl[10] = mk(0, 8'h00, 4'h0, 4'h4, 1, 8'h23, 0, 0);
    tbl[11] = mk(0, 8'h00, 4'hB, 4'h4, 1, 8'h23, 0, 0);
    tbl[12] = mk(1, 8'h00, 4'h4, 4'h0, 1, 8'h23, 0, 0);
    tbl[13] = mk(1, 8'h21, 4'h4, 4'h0, 1, 8'h23, 0, 1);
    tbl[14] = mk(0, 8'h00, 4'h0, 4'h0, 0, 8'h00, 0, 0);
    tbl[15] = mk(1, 8'h24, 4'h0, 4'h0, 1, 8'h24, 0, 0);
    tbl[16] = mk(0, 8'h00, 4'h0, 4'h8, 1, 8'h24, 0, 0);
    tbl[17] = mk(1, 8'h00, 4'h0, 4'h0, 1, 8'h24, 0, 0);
    tbl[18] = mk(0, 8'h00, 4'h8, 4'h0, 1, 8'h24, 0, 0);
    tbl[19] = mk(0, 8'h00, 4'h0, 4'h0, 0, 8'h00, 0, 0);
    tbl[20] = mk(1, 8'h00, 4'h0, 4'h0, 0, 8'h00, 0, 0);
    tbl[21] = mk(1, 8'h25, 4'h0, 4'h0, 0, 8'h00, 1, 0);
    tbl[22] = mk(1, 8'h20, 4'h0, 4'h0, 0, 8'h00, 1, 0);
    tbl[23] = mk(0, 8'h00, 4'h0, 4'h0, 0, 8'h00, 1, 0);
    tbl[24] = mk(1, 8'h00, 4'h0, 4'h0, 0, 8'h00, 1, 0);

    for (int i = 0; i < 25; i++) begin
      step(tbl[i].v, tbl[i].d, tbl[i].dn);
      chk_out($sformatf("vec%0d", i), tbl[i].act, tbl[i].busy, tbl[i].code,
              tbl[i].unk, 1'b0, tbl[i].drop);
    end

    // Two-cycle activate latency, done raised after 10 activate cycles.
    step(1, 8'h22, 4'h0);
    chk_out("lat_arm", 4'h0, 1'b1, 8'h22, 1'b0, 1'b0, 1'b0);
    step(0, 8'h00, 4'h0);
    chk_out("lat_run", 4'h2, 1'b1, 8'h22, 1'b0, 1'b0, 1'b0);
    for (int i = 0; i < 9; i++) begin
      step(0, 8'h00, 4'h0);
      chk($sformatf("hold_run%0d", i), 32'(ch_activate), 32'h2);
    end
    step(0, 8'h00, 4'h2);
    chk_out("done_release", 4'h0, 1'b1, 8'h22, 1'b0, 1'b0, 1'b0);
    step(0, 8'h00, 4'h2);
    chk("release_hold.busy", 32'(busy), 32'h1);
    step(0, 8'h00, 4'h0);
    chk_out("done_idle", 4'h0, 1'b0, 8'h00, 1'b0, 1'b0, 1'b0);

    // Run with done never set: timeout ends it only when the feature is built.
    step(1, 8'h21, 4'h0);
    n_act = 0;
    for (int i = 0; i < 40; i++) begin
      step(0, 8'h00, 4'h0);
      if (ch_activate != '0) n_act++;
    end
    chk("timeout_run_len", 32'(n_act), TO_EN ? 32'd16 : 32'd40);
    chk("timeout_flag", 32'(err_timeout), 32'(TO_EN));
    chk("timeout_busy", 32'(busy), 32'(!TO_EN));
    if (!TO_EN) begin
      step(1, ABORT, 4'h0);
      chk("abort_drop.activate", 32'(ch_activate), 32'h0);
      step(0, 8'h00, 4'h0);
      chk("abort_idle.busy", 32'(busy), 32'h0);
    end
    step(1, 8'h22, 4'h0);
    chk("timeout_cleared", 32'(err_timeout), 32'h0);
    step(0, 8'h00, 4'h0);
    step(0, 8'h00, 4'h2);
    step(0, 8'h00, 4'h0);
    chk_out("after_timeout_idle", 4'h0, 1'b0, 8'h00, 1'b0, 1'b0, 1'b0);

    // Asynchronous reset in the middle of RUN, checked before any edge.
    step(1, 8'h23, 4'h0);
    step(0, 8'h00, 4'h0);
    chk("pre_reset.activate", 32'(ch_activate), 32'h4);
    #2 rst_n = 1'b0;
    #1 chk_out("reset_midrun", 4'h0, 1'b0, ABORT, 1'b0, 1'b0, 1'b0);
    @(negedge clk);
    rst_n = 1'b1;
    model_reset();
    step(0, 8'h00, 4'h0);
    chk_out("post_reset", 4'h0, 1'b0, ABORT, 1'b0, 1'b0, 1'b0);

    // Randomized traffic against the model.
    done_r = '0;
    for (int i = 0; i < 1500; i++) begin
      rv = ($urandom_range(0, 3) == 0);
      case ($urandom_range(0, 7))
        0, 1, 2, 3: rd = BASE + 8'($urandom_range(0, 3));
        4:          rd = ABORT;
        5:          rd = 8'h25;
        6:          rd = 8'h11;
        default:    rd = 8'($urandom);
      endcase
      for (int b = 0; b < NCH; b++)
        if ($urandom_range(0, 5) == 0) done_r[b] = ~done_r[b];
      step(rv, rd, done_r);
      chk_model($sformatf("rnd%0d", i));
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
